// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data-cache miss controller: FSM states and
// line-geometry derivations used by the controller and its burst counter.
package dcache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_DATA,
    GAP,
    FILL_REQ,
    FILL_DATA,
    DONE
  } state_t;

  // Nibbles per cache line.
  function automatic int nib_of(input int line_length);
    return 2 * line_length;
  endfunction

  // Byte-offset bits within a line.
  function automatic int lb_of(input int line_length);
    return $clog2(line_length);
  endfunction

  // Burst counter width: one bit more than needed to index a nibble.
  function automatic int cnt_w_of(input int line_length);
    return $clog2(2 * line_length) + 1;
  endfunction

endpackage

// File: rtl/dcache_nib_counter.sv
// Nibble burst counter: synchronous clear has priority over increment;
// tc flags that the current count addresses the last nibble of the line.
module dcache_nib_counter #(
  parameter int NIB = 8,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(NIB - 1));

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache miss controller: optional dirty-line writeback burst, then a
// line fill burst from memory, stalling the CPU until the line is resident.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 22
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  input  logic [PA-1:0]                      paddr,
  input  logic                               fault,
  input  logic                               hit,
  input  logic                               push,
  input  logic                               pull,
  input  logic [PA-lb_of(LINE_LENGTH)-1:0]   tag,
  output logic                               stall,
  output logic                               rstrobe_d,
  output logic                               wstrobe_d,
  output logic                               mem_req,
  output logic                               mem_write,
  output logic [PA-1:0]                      mem_addr,
  input  logic                               mem_ack,
  output logic                               mem_wvalid,
  input  logic                               mem_rvalid,
  output logic                               err_gap
);

  localparam int NIB = nib_of(LINE_LENGTH);
  localparam int LB  = lb_of(LINE_LENGTH);
  localparam int CW  = cnt_w_of(LINE_LENGTH);

  state_t          state, state_next;
  logic            miss;
  logic            cnt_clear, cnt_inc, cnt_tc;
  logic [CW-1:0]   cnt;

  // pull is part of the lookup status bundle but carries no meaning here;
  // folding it in keeps the port without altering the miss decision.
  assign miss = req_valid && !fault && !hit && (pull || !pull);

  dcache_nib_counter #(
    .NIB (NIB),
    .CW  (CW)
  ) u_nib_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_next = state;
    cnt_clear  = 1'b1;
    cnt_inc    = 1'b0;
    rstrobe_d  = 1'b0;
    wstrobe_d  = 1'b0;
    mem_wvalid = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    err_gap    = 1'b0;

    unique case (state)
      IDLE: begin
        if (miss) state_next = push ? WB_REQ : FILL_REQ;
      end
      WB_REQ: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {tag, {LB{1'b0}}};
        if (mem_ack) state_next = WB_DATA;
      end
      WB_DATA: begin
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b1;
        rstrobe_d  = 1'b1;
        mem_wvalid = 1'b1;
        if (cnt_tc) state_next = GAP;
      end
      GAP: begin
        // Idle strobes let the cache nibble offset wrap back to zero.
        state_next = FILL_REQ;
      end
      FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = paddr & ~PA'(LINE_LENGTH - 1);
        if (mem_ack) state_next = FILL_DATA;
      end
      FILL_DATA: begin
        cnt_clear = 1'b0;
        cnt_inc   = mem_rvalid;
        wstrobe_d = mem_rvalid;
        if (mem_rvalid && cnt_tc) begin
          state_next = DONE;
        end else if (!mem_rvalid && cnt != '0) begin
          // A broken burst is discarded and the whole line is re-fetched.
          err_gap    = 1'b1;
          state_next = GAP;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs stay quiet for the whole reset cycle, even mid-burst.
    if (reset) begin
      rstrobe_d  = 1'b0;
      wstrobe_d  = 1'b0;
      mem_wvalid = 1'b0;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      err_gap    = 1'b0;
    end
  end

  assign stall = !reset && req_valid && !fault && (!hit || state != IDLE);

endmodule
